// File: rtl/seq_double_dabble.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Optional leading-zero blanking mask enabled by SEQ_DOUBLE_DABBLE_BLANK_EN.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | one add-3/shift iteration per clock, counter counts down
// DONE  | result presented with out_valid, held until out_ready
module seq_double_dabble #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef SEQ_DOUBLE_DABBLE_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_mask
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [BCD_W-1:0]     acc;
  logic [CNT_W-1:0]     cnt;

  logic [BCD_W-1:0]     acc_adj;
  logic [BCD_W-1:0]     acc_next;
  logic [BIN_WIDTH-1:0] bin_next;
  logic                 carry_out;
  logic                 last_iter;

  // Correct each digit before the shift so that doubling carries into the next digit.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    {carry_out, acc_next, bin_next} = {acc_adj, bin_sr, 1'b0};
  end

  assign last_iter = (state == SHIFT) && (cnt == CNT_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bin_sr    <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin_sr   <= bin_in;
            acc      <= '0;
            overflow <= 1'b0;
            cnt      <= CNT_W'(BIN_WIDTH);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc    <= acc_next;
          bin_sr <= bin_next;
          cnt    <= cnt - CNT_W'(1);
          if (carry_out)
            overflow <= 1'b1;
          // bcd_out is only refreshed here so the previous result survives the conversion.
          if (last_iter) begin
            bcd_out   <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_DOUBLE_DABBLE_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              zero_above;

  // Digit 0 is never blanked so a zero result still shows one digit.
  always_comb begin
    blank_next = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above    = zero_above & (acc_next[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
    blank_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      blank_mask <= '0;
    else if (last_iter)
      blank_mask <= blank_next;
  end
`endif

endmodule
